// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences instruction-fetch and data accesses onto one
// single-port Memory, holding each access for a programmable window and answering with a ready pulse.
module mem_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wd,
   output logic          m0_ready,
   output logic [DW-1:0] m0_rd,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wd,
   output logic          m1_ready,
   output logic [DW-1:0] m1_rd,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic          gnt_id
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last_grant_q, last_grant_d;
   logic          gnt_q, gnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wd_q, mem_wd_d;
   logic          mem_we_q, mem_we_d;
   logic          m0_ready_q, m0_ready_d;
   logic          m1_ready_q, m1_ready_d;
   logic [DW-1:0] m0_rd_q, m0_rd_d;
   logic [DW-1:0] m1_rd_q, m1_rd_d;

   logic          any_req_s;
   logic          win_s;
   logic          win_we_s;
   logic [AW-1:0] win_addr_s;
   logic [DW-1:0] win_wd_s;

   assign any_req_s  = m0_req | m1_req;
   assign win_we_s   = win_s ? m1_we   : m0_we;
   assign win_addr_s = win_s ? m1_addr : m0_addr;
   assign win_wd_s   = win_s ? m1_wd   : m0_wd;

   // Round-robin pick: on a tie the port that was not served last wins.
   always_comb begin
      if (m0_req && m1_req) begin
         win_s = ~last_grant_q;
      end else if (m1_req) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // State and wait-counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               state_d = ST_ACCESS;
               cnt_d   = WAIT_CNT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Output next values; mem_we is raised one edge early so it is high only in the final ACCESS cycle.
   always_comb begin
      gnt_d        = gnt_q;
      we_d         = we_q;
      mem_addr_d   = mem_addr_q;
      mem_wd_d     = mem_wd_q;
      last_grant_d = last_grant_q;
      m0_rd_d      = m0_rd_q;
      m1_rd_d      = m1_rd_q;
      mem_we_d     = 1'b0;
      m0_ready_d   = 1'b0;
      m1_ready_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               gnt_d      = win_s;
               we_d       = win_we_s;
               mem_addr_d = win_addr_s;
               mem_wd_d   = win_wd_s;
               mem_we_d   = win_we_s & (WAIT_CNT == 4'd0);
            end else begin
               mem_we_d = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               m0_ready_d = ~gnt_q;
               m1_ready_d = gnt_q;
               if (!we_q && gnt_q) begin
                  m1_rd_d = mem_rd;
               end else if (!we_q) begin
                  m0_rd_d = mem_rd;
               end else begin
                  m0_rd_d = m0_rd_q;
               end
            end else if (cnt_q == 4'd1) begin
               mem_we_d = we_q;
            end else begin
               mem_we_d = 1'b0;
            end
         end
         ST_RESP: begin
            last_grant_d = gnt_q;
         end
         default: begin
            mem_we_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_q        <= 1'b0;
         we_q         <= 1'b0;
         mem_addr_q   <= {AW{1'b0}};
         mem_wd_q     <= {DW{1'b0}};
         mem_we_q     <= 1'b0;
         last_grant_q <= 1'b1;
         m0_ready_q   <= 1'b0;
         m1_ready_q   <= 1'b0;
         m0_rd_q      <= {DW{1'b0}};
         m1_rd_q      <= {DW{1'b0}};
      end else begin
         gnt_q        <= gnt_d;
         we_q         <= we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wd_q     <= mem_wd_d;
         mem_we_q     <= mem_we_d;
         last_grant_q <= last_grant_d;
         m0_ready_q   <= m0_ready_d;
         m1_ready_q   <= m1_ready_d;
         m0_rd_q      <= m0_rd_d;
         m1_rd_q      <= m1_rd_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_wd   = mem_wd_q;
   assign mem_we   = mem_we_q;
   assign gnt_id   = gnt_q;
   assign m0_ready = m0_ready_q;
   assign m1_ready = m1_ready_q;
   assign m0_rd    = m0_rd_q;
   assign m1_rd    = m1_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (WAIT_CYCLES 0 and 3), each with its own memory,
// selected by sel; directed scenarios plus randomized rounds against a transaction-level model.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        sel;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;

   logic        m0_req_a, m1_req_a, m0_req_b, m1_req_b;
   logic        m0_ready_a, m1_ready_a, m0_ready_b, m1_ready_b;
   logic [31:0] m0_rd_a, m1_rd_a, m0_rd_b, m1_rd_b;
   logic [31:0] mem_addr_a, mem_wd_a, mem_rd_a, mem_addr_b, mem_wd_b, mem_rd_b;
   logic        mem_we_a, mem_we_b, gnt_a, gnt_b;

   logic        m0_ready, m1_ready, mem_we, gnt_id;
   logic [31:0] m0_rd, m1_rd, mem_addr;

   logic [31:0] mem_a [0:255] = '{default: 32'h0};
   logic [31:0] mem_b [0:255] = '{default: 32'h0};

   int n_vec = 0;
   int n_err = 0;
   int last_port [0:1];
   logic [31:0] model_m [0:7];

   assign m0_req_a = m0_req & ~sel;
   assign m1_req_a = m1_req & ~sel;
   assign m0_req_b = m0_req & sel;
   assign m1_req_b = m1_req & sel;

   assign m0_ready = sel ? m0_ready_b : m0_ready_a;
   assign m1_ready = sel ? m1_ready_b : m1_ready_a;
   assign m0_rd    = sel ? m0_rd_b    : m0_rd_a;
   assign m1_rd    = sel ? m1_rd_b    : m1_rd_a;
   assign mem_we   = sel ? mem_we_b   : mem_we_a;
   assign mem_addr = sel ? mem_addr_b : mem_addr_a;
   assign gnt_id   = sel ? gnt_b      : gnt_a;

   assign mem_rd_a = mem_a[mem_addr_a[9:2]];
   assign mem_rd_b = mem_b[mem_addr_b[9:2]];

   always @(posedge clk) begin
      if (mem_we_a) mem_a[mem_addr_a[9:2]] <= mem_wd_a;
      if (mem_we_b) mem_b[mem_addr_b[9:2]] <= mem_wd_b;
   end

   mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(0)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req_a), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
      .m0_ready(m0_ready_a), .m0_rd(m0_rd_a),
      .m1_req(m1_req_a), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
      .m1_ready(m1_ready_a), .m1_rd(m1_rd_a),
      .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_wd(mem_wd_a), .mem_rd(mem_rd_a),
      .gnt_id(gnt_a));

   mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(3)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req_b), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
      .m0_ready(m0_ready_b), .m0_rd(m0_rd_b),
      .m1_req(m1_req_b), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
      .m1_ready(m1_ready_b), .m1_rd(m1_rd_b),
      .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b),
      .gnt_id(gnt_b));

   function automatic logic [31:0] env_mem(input logic s, input logic [31:0] a);
      logic [7:0] i;
      i = a[9:2];
      return s ? mem_b[i] : mem_a[i];
   endfunction

   // Issue one request on a port, hold it until ready, then release and idle one cycle.
   task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit perturb, output int lat,
                          output logic [31:0] we_mask, output bit addr_ok,
                          output logic tail, output logic [31:0] rd);
      lat = -1; we_mask = 32'h0; addr_ok = 1'b1; rd = 32'h0;
      if (port == 0) begin
         m0_we = we; m0_addr = addr; m0_wd = wd; m0_req = 1'b1;
      end else begin
         m1_we = we; m1_addr = addr; m1_wd = wd; m1_req = 1'b1;
      end
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (mem_we) we_mask[c] = 1'b1;
         if (mem_addr !== addr) addr_ok = 1'b0;
         if (perturb && c == 1) begin
            if (port == 0) begin m0_addr = ~addr; m0_wd = ~wd; m0_we = ~we; end
            else begin m1_addr = ~addr; m1_wd = ~wd; m1_we = ~we; end
         end
         if ((port == 0 && m0_ready === 1'b1) || (port == 1 && m1_ready === 1'b1)) begin
            lat = c;
            rd = (port == 0) ? m0_rd : m1_rd;
            break;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);
      tail = (port == 0) ? m0_ready : m1_ready;
      if (lat > 0) last_port[sel] = port;
   endtask

   task automatic test_reset();
      logic [131:0] va, vb;
      sel = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010; m0_wd = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wd = 32'h0;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      va = {mem_addr_a, mem_we_a, mem_wd_a, m0_ready_a, m1_ready_a, m0_rd_a, m1_rd_a, gnt_a};
      vb = {mem_addr_b, mem_we_b, mem_wd_b, m0_ready_b, m1_ready_b, m0_rd_b, m1_rd_b, gnt_b};
      n_vec++; if (va !== 132'h0) begin n_err++; $display("FAIL reset_outs_a: got %h want 0", va); end
      n_vec++; if (vb !== 132'h0) begin n_err++; $display("FAIL reset_outs_b: got %h want 0", vb); end
      reset_n = 1'b1;
      @(negedge clk);
      n_vec++; if (m0_ready !== 1'b0) begin n_err++; $display("FAIL rst_first_c1_ready: got %b want 0", m0_ready); end
      n_vec++; if (mem_addr !== 32'h0000_0010) begin n_err++; $display("FAIL rst_first_addr: got %h want 00000010", mem_addr); end
      @(negedge clk);
      n_vec++; if ({m0_ready, m1_ready, gnt_id} !== 3'b100) begin n_err++; $display("FAIL rst_first_c2: got r0,r1,gnt=%b want 100", {m0_ready, m1_ready, gnt_id}); end
      m0_req = 1'b0;
      @(negedge clk);
      n_vec++; if (m0_ready !== 1'b0) begin n_err++; $display("FAIL rst_first_pulse: got %b want 0", m0_ready); end
      last_port[0] = 0; last_port[1] = 1;
   endtask

   task automatic test_write_read_p1();
      int lat; logic [31:0] wm, rd; bit aok; logic tail;
      sel = 1'b0;
      run_txn(1, 1'b1, 32'h0000_1234, 32'hA5A5_A5A5, 1'b0, lat, wm, aok, tail, rd);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL wr_lat: got %0d want 2", lat); end
      n_vec++; if (wm !== 32'h2) begin n_err++; $display("FAIL wr_we_mask: got %h want 00000002", wm); end
      n_vec++; if (tail !== 1'b0) begin n_err++; $display("FAIL wr_ready_width: got %b want 0", tail); end
      n_vec++; if (env_mem(1'b0, 32'h1234) !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL wr_mem: got %h want a5a5a5a5", env_mem(1'b0, 32'h1234)); end
      run_txn(1, 1'b0, 32'h0000_1234, 32'h0, 1'b0, lat, wm, aok, tail, rd);
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL rd_lat: got %0d want 2", lat); end
      n_vec++; if (rd !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL rd_data_p1: got %h want a5a5a5a5", rd); end
      n_vec++; if (wm !== 32'h0) begin n_err++; $display("FAIL rd_we_mask: got %h want 0", wm); end
      n_vec++; if (m0_rd !== 32'h0) begin n_err++; $display("FAIL rd_m0_untouched: got %h want 0", m0_rd); end
   endtask

   task automatic test_write_isolation();
      int lat; logic [31:0] wm, rd; bit aok; logic tail;
      sel = 1'b0;
      run_txn(1, 1'b1, 32'h0000_123C, 32'hA5A5_A596, 1'b0, lat, wm, aok, tail, rd);
      n_vec++; if (wm !== 32'h2) begin n_err++; $display("FAIL iso_we_mask: got %h want 00000002", wm); end
      run_txn(0, 1'b0, 32'h0000_1234, 32'h0, 1'b0, lat, wm, aok, tail, rd);
      n_vec++; if (rd !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL iso_rd_1234: got %h want a5a5a5a5", rd); end
      run_txn(0, 1'b0, 32'h0000_123C, 32'h0, 1'b0, lat, wm, aok, tail, rd);
      n_vec++; if (rd !== 32'hA5A5_A596) begin n_err++; $display("FAIL iso_rd_123c: got %h want a5a5a596", rd); end
      n_vec++; if (m1_rd !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL iso_m1_held: got %h want a5a5a5a5", m1_rd); end
   endtask

   task automatic test_round_robin();
      int k, exp_p, next_c, p;
      sel = 1'b0;
      m0_we = 1'b0; m0_addr = 32'h0000_1234; m1_we = 1'b0; m1_addr = 32'h0000_123C;
      m0_req = 1'b1; m1_req = 1'b1;
      k = 0; exp_p = 1 - last_port[0]; next_c = 2;
      for (int c = 1; c <= 40 && k < 6; c++) begin
         @(negedge clk);
         n_vec++; if (m0_ready && m1_ready) begin n_err++; $display("FAIL rr_both_ready: got 11 want at most one at cycle %0d", c); end
         if (m0_ready || m1_ready) begin
            p = m1_ready ? 1 : 0;
            n_vec++; if (p !== exp_p) begin n_err++; $display("FAIL rr_order: got port %0d want %0d", p, exp_p); end
            n_vec++; if (c !== next_c) begin n_err++; $display("FAIL rr_spacing: got cycle %0d want %0d", c, next_c); end
            n_vec++; if (gnt_id !== p[0]) begin n_err++; $display("FAIL rr_gnt_id: got %b want %0d", gnt_id, p); end
            n_vec++;
            if ((p == 0 ? m0_rd : m1_rd) !== (p == 0 ? 32'hA5A5_A5A5 : 32'hA5A5_A596)) begin
               n_err++; $display("FAIL rr_rd: got %h on port %0d", (p == 0 ? m0_rd : m1_rd), p);
            end
            last_port[0] = p; exp_p = 1 - p; next_c = next_c + 3; k++;
            if (k == 6) begin m0_req = 1'b0; m1_req = 1'b0; end
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      n_vec++; if (k !== 6) begin n_err++; $display("FAIL rr_timeout: got %0d completions want 6", k); end
      @(negedge clk);
   endtask

   task automatic test_wait_states();
      int lat; logic [31:0] wm, rd; bit aok; logic tail;
      sel = 1'b1;
      run_txn(0, 1'b1, 32'h0000_0040, 32'hCAFE_0001, 1'b1, lat, wm, aok, tail, rd);
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL ws_wr_lat: got %0d want 5", lat); end
      n_vec++; if (wm !== 32'h10) begin n_err++; $display("FAIL ws_we_mask: got %h want 00000010", wm); end
      n_vec++; if (aok !== 1'b1) begin n_err++; $display("FAIL ws_wr_addr_stable: got %b want 1", aok); end
      n_vec++; if (env_mem(1'b1, 32'h40) !== 32'hCAFE_0001) begin n_err++; $display("FAIL ws_wr_mem: got %h want cafe0001", env_mem(1'b1, 32'h40)); end
      n_vec++; if (env_mem(1'b1, 32'hFFFF_FFBF) !== 32'h0) begin n_err++; $display("FAIL ws_perturb_addr: got %h want 0", env_mem(1'b1, 32'hFFFF_FFBF)); end
      run_txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, lat, wm, aok, tail, rd);
      n_vec++; if (lat !== 5) begin n_err++; $display("FAIL ws_rd_lat: got %0d want 5", lat); end
      n_vec++; if (rd !== 32'hCAFE_0001) begin n_err++; $display("FAIL ws_rd_data: got %h want cafe0001", rd); end
      n_vec++; if ({aok, tail, wm} !== {1'b1, 1'b0, 32'h0}) begin n_err++; $display("FAIL ws_rd_misc: got aok=%b tail=%b wm=%h want 1 0 0", aok, tail, wm); end
   endtask

   task automatic test_reset_mid_write();
      int lat, seen; logic [31:0] wm, rd; bit aok; logic tail;
      sel = 1'b1;
      m0_we = 1'b1; m0_addr = 32'h0000_0040; m0_wd = 32'hDEAD_BEEF; m0_req = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL mid_final_we: got %b want 1", mem_we); end
      #1 reset_n = 1'b0;
      #1;
      n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL mid_we_async_drop: got %b want 0", mem_we); end
      m0_req = 1'b0;
      seen = 0;
      repeat (2) begin @(negedge clk); if (m0_ready || m1_ready) seen++; end
      reset_n = 1'b1;
      n_vec++; if (env_mem(1'b1, 32'h40) !== 32'hCAFE_0001) begin n_err++; $display("FAIL mid_mem_kept: got %h want cafe0001", env_mem(1'b1, 32'h40)); end
      repeat (6) begin @(negedge clk); if (m0_ready || m1_ready) seen++; end
      n_vec++; if (seen !== 0) begin n_err++; $display("FAIL mid_no_ready: got %0d pulses want 0", seen); end
      last_port[0] = 1; last_port[1] = 1;
      run_txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, lat, wm, aok, tail, rd);
      n_vec++; if (rd !== 32'hCAFE_0001) begin n_err++; $display("FAIL mid_readback: got %h want cafe0001", rd); end
   endtask

   // Random rounds: model predicts serving order, completion cycle and read data.
   task automatic test_random(input logic s);
      int w, mode, n, done, p;
      int order [0:1];
      logic       we_r [0:1];
      int         k_r  [0:1];
      logic [31:0] wd_r [0:1];
      sel = s;
      w = s ? 3 : 0;
      for (int i = 0; i < 8; i++) model_m[i] = 32'h0;
      for (int it = 0; it < 14; it++) begin
         mode = $urandom_range(1, 3);
         for (int q = 0; q < 2; q++) begin
            we_r[q] = 1'($urandom_range(0, 1));
            k_r[q]  = $urandom_range(0, 7);
            wd_r[q] = $urandom;
         end
         m0_we = we_r[0]; m0_addr = 32'h100 + (32'(k_r[0]) << 2); m0_wd = wd_r[0];
         m1_we = we_r[1]; m1_addr = 32'h100 + (32'(k_r[1]) << 2); m1_wd = wd_r[1];
         m0_req = mode[0]; m1_req = mode[1];
         if (mode == 3) begin
            n = 2; order[0] = 1 - last_port[s]; order[1] = last_port[s];
         end else begin
            n = 1; order[0] = (mode == 2) ? 1 : 0; order[1] = 0;
         end
         done = 0;
         for (int c = 1; c <= 40 && done < n; c++) begin
            @(negedge clk);
            n_vec++; if (m0_ready && m1_ready) begin n_err++; $display("FAIL rnd_both_ready: got 11 want at most one"); end
            if (m0_ready || m1_ready) begin
               p = m1_ready ? 1 : 0;
               n_vec++; if (p !== order[done]) begin n_err++; $display("FAIL rnd_order: got port %0d want %0d", p, order[done]); end
               n_vec++; if (c !== (w + 2) + done * (w + 3)) begin n_err++; $display("FAIL rnd_latency: got %0d want %0d", c, (w + 2) + done * (w + 3)); end
               if (we_r[p]) begin
                  model_m[k_r[p]] = wd_r[p];
               end else begin
                  n_vec++;
                  if ((p == 0 ? m0_rd : m1_rd) !== model_m[k_r[p]]) begin
                     n_err++; $display("FAIL rnd_rd: got %h want %h port %0d", (p == 0 ? m0_rd : m1_rd), model_m[k_r[p]], p);
                  end
               end
               if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
               last_port[s] = p;
               done++;
            end
         end
         m0_req = 1'b0; m1_req = 1'b0;
         n_vec++; if (done !== n) begin n_err++; $display("FAIL rnd_timeout: got %0d completions want %0d", done, n); end
         @(negedge clk);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (env_mem(s, 32'h100 + (32'(i) << 2)) !== model_m[i]) begin
            n_err++; $display("FAIL rnd_mem_final: got %h want %h word %0d", env_mem(s, 32'h100 + (32'(i) << 2)), model_m[i], i);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      sel = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0;
      last_port[0] = 1; last_port[1] = 1;
      test_reset();
      test_write_read_p1();
      test_write_isolation();
      test_round_robin();
      test_wait_states();
      test_reset_mid_write();
      test_random(1'b0);
      test_random(1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer for the unified single-port Memory in the multicycle processor.
- Port 0 is instruction fetch and port 1 is data load/store. Both share one Memory instance: combinational read, write on clk edge when MemWrite=1.
- Serialises requests with round-robin fairness, holds the Memory address/data/write-enable stable for a programmable access window, and returns read data with a one-cycle ready pulse.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_CYCLES, 0, extra access-window cycles before the write/capture edge (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  port-0 request; held until m0_ready.
- m0_we  in  1  port-0 write (1) / read (0).
- m0_addr  in  AW  port-0 address.
- m0_wd  in  DW  port-0 write data.
- m0_ready  out  1  port-0 completion pulse.
- m0_rd  out  DW  port-0 read data.
- m1_req, m1_we, m1_addr, m1_wd, m1_ready, m1_rd: same roles and widths for port 1.
- mem_addr  out  AW  to Memory addr.
- mem_we  out  1  to Memory MemWrite.
- mem_wd  out  DW  to Memory WD.
- mem_rd  in  DW  from Memory RD.
- gnt_id  out  1  port currently or last served.

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - State=IDLE; all outputs 0, including mem_we, mem_addr, mem_wd, m0_ready, m1_ready, m0_rd, m1_rd and gnt_id.
  - last_grant=1, so port 0 wins the first tie.
  - An in-flight write is abandoned. mem_we drops asynchronously, so no partial or late write occurs.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req inputs are sampled only here.
  - No req: stay in IDLE, mem_we=0, mem_addr holds its last value.
  - One req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant, latch addr/we/wd of the winner, set gnt_id, load wait counter with WAIT_CYCLES, go to ACCESS.
- ACCESS:
  - mem_addr and mem_wd driven from latched registers, stable for the whole window.
  - Counter decrements each cycle.
  - mem_we=latched_we only in the final ACCESS cycle (counter==0), and is 0 in all earlier ACCESS cycles.
  - On the final edge the Memory performs the write, or the arbiter captures mem_rd into the winner's rd register for reads. Then go to RESP.
- RESP:
  - Winner's ready=1 for exactly one cycle; the other port's ready=0.
  - mem_we=0.
  - last_grant=gnt_id. Go to IDLE.
- Handshake:
  - A transaction completes on the clk edge where ready=1.
  - The requester must hold req/we/addr/wd constant from assertion until that edge.
  - Values presented after that edge form a new request, sampled in the following IDLE cycle.
  - Changes to the granted port's inputs after the grant are ignored (latched copy used).
- Latency: req seen in IDLE to ready high = WAIT_CYCLES+2 cycles. Back-to-back throughput = one access per WAIT_CYCLES+3 cycles.
- Read data:
  - m0_rd and m1_rd are separate registers, updated only on that port's read completion.
  - Held otherwise; writes leave them unchanged.
- Losing requester: waits with req high. It is guaranteed service on the next grant (round-robin, so no starvation).
- No address decoding or alignment checks; addresses pass through unchanged.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles with m0_req=1 → all outputs 0; after release, first grant goes to port 0, m0_ready at cycle 2 (WAIT_CYCLES=0).
- Single write then read on port 1: write 32'hA5A5A5A5 to 32'h00001234, then read the same address → mem_we high exactly 1 cycle; m1_rd=32'hA5A5A5A5 with m1_ready pulse; m0_rd stays 0.
- Simultaneous requests held continuously: both ports request → grants alternate 0,1,0,1 (gnt_id); each ready pulse is 3 cycles apart; never both readies high.
- Write isolation: port 1 writes 32'hA5A5A596 to 32'h0000123C, then port 0 reads 32'h00001234 → m0_rd=32'hA5A5A5A5 (unchanged); reading 32'h0000123C gives 32'hA5A5A596.
- Wait states, WAIT_CYCLES=3: read request → mem_addr stable 4 cycles, ready at cycle 5. For a write, mem_we is asserted only in the 4th ACCESS cycle. Changing m0_addr after the grant has no effect.
- Reset mid-write: assert reset_n=0 during ACCESS with WAIT_CYCLES=3 → mem_we 0 immediately; the target location keeps its old value; no ready pulse is issued.
